// File: rtl/rf_wb_pkg.sv
// Shared constants and helpers for the register-file writeback scheduler.
package rf_wb_pkg;

  localparam int rf_wb_src_pipe_gp = 0;

  // Never returns 0, so single-entry structures still get a 1-bit index.
  function automatic int rf_wb_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Writeback request bus between the N sources and the scheduler.
// valid/ready: a source raises v[i] with addr/data stable and holds them until yumi[i] is
// seen high in the same cycle; yumi is combinational and v must never depend on yumi.
interface rf_wb_scheduler_if #(
  parameter int width_p      = 32,
  parameter int addr_width_p = 5,
  parameter int num_src_p    = 3
);
  logic [num_src_p-1:0]              v;
  logic [num_src_p*addr_width_p-1:0] addr;
  logic [num_src_p*width_p-1:0]      data;
  logic [num_src_p-1:0]              yumi;
  logic                              stall;

  modport master (output v, addr, data, input yumi, stall);
  modport slave  (input v, addr, data, output yumi, stall);
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Per-register pending bits for in-flight long-latency results; a set beats a clear
// to the same register in the same cycle.
module rf_wb_scoreboard
  import rf_wb_pkg::*;
#(
  parameter int els_p      = 32,
  parameter int zero_reg_p = 1,
  localparam int addr_width_lp = rf_wb_safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     set_v_i,
  input  logic [addr_width_lp-1:0] set_addr_i,
  input  logic                     clr_v_i,
  input  logic [addr_width_lp-1:0] clr_addr_i,
  output logic [els_p-1:0]         pending_o
);

  logic [els_p-1:0] set_hot;
  logic [els_p-1:0] clr_hot;

  always_comb begin
    set_hot = set_v_i ? (els_p'(1) << set_addr_i) : '0;
    if (zero_reg_p != 0) set_hot[0] = 1'b0;
    clr_hot = clr_v_i ? (els_p'(1) << clr_addr_i) : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_o <= '0;
    end else begin
      pending_o <= (pending_o & ~clr_hot) | set_hot;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Owns the RF write port: src 0 (pipeline) has priority, srcs 1..N-1 round-robin and
// preempt src 0 after max_wait_p consecutive denied cycles.
module rf_wb_scheduler
  import rf_wb_pkg::*;
#(
  parameter int width_p    = 32,
  parameter int els_p      = 32,
  parameter int num_src_p  = 3,
  parameter int max_wait_p = 8,
  parameter int zero_reg_p = 1,
  localparam int addr_width_lp = rf_wb_safe_clog2(els_p),
  localparam int wait_width_lp = rf_wb_safe_clog2(max_wait_p + 1),
  localparam int src_width_lp  = rf_wb_safe_clog2(num_src_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  rf_wb_scheduler_if.slave         bus,
  output logic                     w_v_o,
  output logic [addr_width_lp-1:0] w_addr_o,
  output logic [width_p-1:0]       w_data_o,
  input  logic                     sb_set_v_i,
  input  logic [addr_width_lp-1:0] sb_set_addr_i,
  output logic [els_p-1:0]         sb_pending_o,
  output logic [wait_width_lp-1:0] dbg_wait_cnt_o,
  output logic [src_width_lp-1:0]  dbg_rr_ptr_o
);

  typedef struct packed {
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0]       data;
  } rf_wb_req_s;

  rf_wb_req_s req [num_src_p];

  for (genvar i = 0; i < num_src_p; i++) begin : g_req
    assign req[i] = {bus.addr[i*addr_width_lp +: addr_width_lp],
                     bus.data[i*width_p +: width_p]};
  end

  // rr_ptr names the long-latency source searched first on the next arbitration.
  logic [src_width_lp-1:0]  rr_ptr;
  logic [wait_width_lp-1:0] wait_cnt;

  logic                     any_hi;
  logic                     starve;
  logic                     hi_found;
  logic [src_width_lp-1:0]  hi_idx;
  logic [src_width_lp-1:0]  cand_idx;
  int                       cand;
  logic                     gnt_v;
  logic [src_width_lp-1:0]  gnt_idx;
  logic                     gnt_hi;
  logic                     gnt_drop;
  logic [num_src_p-1:0]     yumi;
  rf_wb_req_s               gnt_req;

  always_comb begin
    any_hi   = |bus.v[num_src_p-1:1];
    starve   = (wait_cnt == wait_width_lp'(max_wait_p)) && any_hi;
    hi_found = 1'b0;
    hi_idx   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < num_src_p - 1; k++) begin
      cand     = ((int'(rr_ptr) - 1 + k) % (num_src_p - 1)) + 1;
      cand_idx = src_width_lp'(cand);
      if (!hi_found && bus.v[cand_idx]) begin
        hi_found = 1'b1;
        hi_idx   = cand_idx;
      end
    end

    gnt_v   = 1'b0;
    gnt_idx = '0;
    if (bus.v[rf_wb_src_pipe_gp] && !starve) begin
      gnt_v   = 1'b1;
      gnt_idx = src_width_lp'(rf_wb_src_pipe_gp);
    end else if (hi_found) begin
      gnt_v   = 1'b1;
      gnt_idx = hi_idx;
    end

    yumi     = gnt_v ? (num_src_p'(1) << gnt_idx) : '0;
    gnt_hi   = gnt_v && (gnt_idx != src_width_lp'(rf_wb_src_pipe_gp));
    gnt_req  = req[gnt_idx];
    gnt_drop = (zero_reg_p != 0) && (gnt_req.addr == '0);
  end

  // Handshake outputs are forced quiet while reset is held, without waiting for a clock.
  assign bus.yumi  = reset_n_i ? yumi : '0;
  assign bus.stall = reset_n_i & bus.v[rf_wb_src_pipe_gp] & ~yumi[rf_wb_src_pipe_gp];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_o    <= 1'b0;
      w_addr_o <= '0;
      w_data_o <= '0;
      rr_ptr   <= src_width_lp'(1);
      wait_cnt <= '0;
    end else begin
      w_v_o <= gnt_v && !gnt_drop;
      if (gnt_v && !gnt_drop) begin
        w_addr_o <= gnt_req.addr;
        w_data_o <= gnt_req.data;
      end

      if (gnt_hi) begin
        rr_ptr <= (gnt_idx == src_width_lp'(num_src_p - 1)) ? src_width_lp'(1)
                                                             : gnt_idx + 1'b1;
      end

      if (gnt_hi || !any_hi) begin
        wait_cnt <= '0;
      end else if (wait_cnt != wait_width_lp'(max_wait_p)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  rf_wb_scoreboard #(
    .els_p      (els_p),
    .zero_reg_p (zero_reg_p)
  ) scoreboard (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .set_v_i    (sb_set_v_i),
    .set_addr_i (sb_set_addr_i),
    .clr_v_i    (gnt_hi),
    .clr_addr_i (gnt_req.addr),
    .pending_o  (sb_pending_o)
  );

  assign dbg_wait_cnt_o = wait_cnt;
  assign dbg_rr_ptr_o   = rr_ptr;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Randomised and directed stimulus for rf_wb_scheduler against a cycle-level
// reference model of the arbitration, write-port and scoreboard rules.
module tb_rf_wb_scheduler;

  localparam int W     = 32;
  localparam int ELS   = 32;
  localparam int N     = 3;
  localparam int MAXW  = 8;
  localparam int AW    = 5;
  localparam int REC_W = 1 + AW + W;

  // clock / reset
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  rf_wb_scheduler_if #(.width_p(W), .addr_width_p(AW), .num_src_p(N)) bus();

  logic            w_v;
  logic [AW-1:0]   w_addr;
  logic [W-1:0]    w_data;
  logic            sb_set_v;
  logic [AW-1:0]   sb_set_addr;
  logic [ELS-1:0]  sb_pending;
  logic [3:0]      dbg_wait;
  logic [1:0]      dbg_rr;

  rf_wb_scheduler #(
    .width_p(W), .els_p(ELS), .num_src_p(N), .max_wait_p(MAXW), .zero_reg_p(1)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .bus            (bus),
    .w_v_o          (w_v),
    .w_addr_o       (w_addr),
    .w_data_o       (w_data),
    .sb_set_v_i     (sb_set_v),
    .sb_set_addr_i  (sb_set_addr),
    .sb_pending_o   (sb_pending),
    .dbg_wait_cnt_o (dbg_wait),
    .dbg_rr_ptr_o   (dbg_rr)
  );

  // reference model state
  int             m_wait;
  int             m_next;
  logic [ELS-1:0] m_pend;
  bit             src_v [N];
  int             src_a [N];
  logic [W-1:0]   src_d [N];
  bit             refill;
  logic [REC_W-1:0] exp_q[$];

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic new_req(input int s, input int a);
    src_v[s] = 1'b1;
    src_a[s] = a;
    src_d[s] = $urandom;
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < N; s++) src_v[s] = 1'b0;
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_next = 1;
    m_pend = '0;
    exp_q.delete();
  endtask

  // One bus cycle: drive at negedge, check combinational handshake, then registered state.
  task automatic step(input bit set_v, input int set_a);
    int               g;
    bit               any_hi;
    bit               starve;
    logic [N-1:0]     vv;
    logic [N-1:0]     exp_yumi;
    logic [REC_W-1:0] rec;
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      vv[s] = src_v[s];
      bus.addr[s*AW +: AW] = AW'(src_a[s]);
      bus.data[s*W +: W]   = src_d[s];
    end
    bus.v       = vv;
    sb_set_v    = set_v;
    sb_set_addr = AW'(set_a);
    #1;
    any_hi = 1'b0;
    for (int s = 1; s < N; s++) any_hi |= vv[s];
    starve = (m_wait == MAXW) && any_hi;
    g = -1;
    if (vv[0] && !starve) g = 0;
    else begin
      for (int k = 0; k < N - 1; k++) begin
        int s;
        s = ((m_next - 1 + k) % (N - 1)) + 1;
        if (g < 0 && vv[s]) g = s;
      end
    end
    exp_yumi = '0;
    if (g >= 0) exp_yumi[g] = 1'b1;
    check("yumi", 64'(bus.yumi), 64'(exp_yumi));
    check("stall", 64'(bus.stall), 64'(vv[0] && (g != 0)));

    if (g >= 0 && src_a[g] != 0) exp_q.push_back({1'b1, AW'(src_a[g]), src_d[g]});
    else exp_q.push_back('0);
    if (g > 0) m_pend[src_a[g]] = 1'b0;
    if (set_v && set_a != 0) m_pend[set_a] = 1'b1;
    if (g > 0 || !any_hi) m_wait = 0;
    else if (m_wait < MAXW) m_wait++;
    if (g > 0) m_next = (g % (N - 1)) + 1;
    if (g >= 0) begin
      if (refill) new_req(g, $urandom_range(1, ELS - 1));
      else src_v[g] = 1'b0;
    end

    @(posedge clk);
    #1;
    rec = exp_q.pop_front();
    check("w_v", 64'(w_v), 64'(rec[REC_W-1]));
    if (rec[REC_W-1]) begin
      check("w_addr", 64'(w_addr), 64'(rec[W +: AW]));
      check("w_data", 64'(w_data), 64'(rec[W-1:0]));
    end
    check("pending", 64'(sb_pending), 64'(m_pend));
    check("wait_cnt", 64'(dbg_wait), 64'(m_wait));
    check("rr_ptr", 64'(dbg_rr), 64'(m_next));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    refill = 1'b0;
    clear_srcs();
    for (int s = 0; s < N; s++) begin
      src_a[s] = 0;
      src_d[s] = '0;
    end
    bus.v = '1;
    bus.addr = '0;
    bus.data = '0;
    sb_set_v = 1'b0;
    sb_set_addr = '0;
    model_reset();

    // reset state, with all sources requesting
    #1 reset_n = 1'b0;
    #2;
    check("rst_w_v", 64'(w_v), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_w_data", 64'(w_data), 64'd0);
    check("rst_pending", 64'(sb_pending), 64'd0);
    check("rst_yumi", 64'(bus.yumi), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_wait", 64'(dbg_wait), 64'd0);
    check("rst_rr", 64'(dbg_rr), 64'd1);
    bus.v = '0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // pipeline write: same-cycle yumi, write one cycle later
    new_req(0, 5);
    src_d[0] = 32'hA5;
    step(1'b0, 0);
    step(1'b0, 0);

    // two long-latency sources alternate with no bubbles
    refill = 1'b1;
    new_req(1, 3);
    new_req(2, 4);
    repeat (4) step(1'b0, 0);
    refill = 1'b0;
    clear_srcs();
    step(1'b0, 0);

    // starvation guard preempts the pipeline
    refill = 1'b1;
    new_req(0, 11);
    new_req(1, 12);
    repeat (12) step(1'b0, 0);
    refill = 1'b0;
    clear_srcs();
    step(1'b0, 0);

    // scoreboard set, clear by src 2, then set+clear collision
    step(1'b1, 7);
    new_req(2, 7);
    step(1'b0, 0);
    step(1'b1, 7);
    new_req(2, 7);
    step(1'b1, 7);
    step(1'b0, 0);

    // register 0 writes and sets are dropped
    new_req(1, 0);
    step(1'b0, 0);
    step(1'b1, 0);

    // reset in the middle of a burst
    refill = 1'b1;
    new_req(1, 9);
    new_req(2, 10);
    step(1'b1, 20);
    step(1'b1, 21);
    check("pre_rst_w_v", 64'(w_v), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_w_v", 64'(w_v), 64'd0);
    check("mid_rst_pending", 64'(sb_pending), 64'd0);
    check("mid_rst_yumi", 64'(bus.yumi), 64'd0);
    model_reset();
    refill = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);
    clear_srcs();
    step(1'b0, 0);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      bit sv;
      if (!src_v[0] && $urandom_range(0, 1) == 0) new_req(0, $urandom_range(0, ELS - 1));
      for (int s = 1; s < N; s++)
        if (!src_v[s] && $urandom_range(0, 3) == 0) new_req(s, $urandom_range(0, ELS - 1));
      sv = ($urandom_range(0, 3) == 0);
      step(sv, $urandom_range(0, ELS - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
